relu_drain_ctrl: RTL

Sequences draining of systolic-array result rows through the ReLU stage into the output buffer write port, one row of COUNT lanes per transfer. A job is launched by a start pulse carrying a row count, base address and per-job ReLU enable. The block applies valid/ready backpressure on both sides, generates sequential buffer addresses and counts lanes clipped to zero. It sits between the accumulator/array output and the output SRAM writer.

---
 rtl/relu_drain_ctrl_pkg.sv | 26 ++
 rtl/relu_drain_ctrl_if.sv | 40 ++++
 rtl/relu_drain_ctrl_relu.sv | 23 ++
 rtl/relu_drain_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/relu_drain_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// relu_drain_ctrl_pkg : shared FSM state and lane-slicing helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
package relu_drain_ctrl_pkg;

   localparam int unsigned C_LANE_W_DEF = 16;
   localparam int unsigned C_LANES_DEF  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } drain_state_t;

   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

   function automatic int unsigned sign_bit(input int unsigned lane, input int unsigned width);
      return lane * width + width - 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/relu_drain_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// relu_drain_ctrl_if : job control plus input/output row streams
// Revision: 1.0
// ---------------------------------------------------------------------------
interface relu_drain_ctrl_if #(
   parameter int WIDTH  = 16,
   parameter int COUNT  = 4,
   parameter int ADDR_W = 8,
   parameter int ROWS_W = 8,
   parameter int NEG_W  = 16
) ();
   logic                     start;
   logic                     cfg_apply_relu;
   logic [ROWS_W-1:0]        cfg_num_rows;
   logic [ADDR_W-1:0]        cfg_base_addr;
   logic                     busy;
   logic                     done;
   logic                     in_valid;
   logic [COUNT*WIDTH-1:0]   in_data;
   logic                     in_ready;
   logic                     out_valid;
   logic                     out_ready;
   logic [ADDR_W-1:0]        out_addr;
   logic [COUNT*WIDTH-1:0]   out_data;
   logic [NEG_W-1:0]         neg_count;

   modport slave (
      input  start, cfg_apply_relu, cfg_num_rows, cfg_base_addr,
      input  in_valid, in_data, out_ready,
      output busy, done, in_ready, out_valid, out_addr, out_data, neg_count
   );

   modport master (
      output start, cfg_apply_relu, cfg_num_rows, cfg_base_addr,
      output in_valid, in_data, out_ready,
      input  busy, done, in_ready, out_valid, out_addr, out_data, neg_count
   );
endinterface
`default_nettype wire

// File: rtl/relu_drain_ctrl_relu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// relu_layer : combinational per-lane ReLU, bypassed when i_apply is low
// Revision: 1.0
// ---------------------------------------------------------------------------
module relu_layer
   import relu_drain_ctrl_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int COUNT = 4
) (
   input  wire logic                   i_apply,
   input  wire logic [COUNT*WIDTH-1:0] i_data,
   output logic      [COUNT*WIDTH-1:0] o_data
);

   for (genvar g = 0; g < COUNT; g++) begin : g_lane
      assign o_data[lane_lsb(g, WIDTH) +: WIDTH] =
         (i_apply && i_data[sign_bit(g, WIDTH)]) ? '0 : i_data[lane_lsb(g, WIDTH) +: WIDTH];
   end

endmodule
`default_nettype wire

// File: rtl/relu_drain_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// relu_drain_ctrl : drains array rows through ReLU into the output buffer port
// Revision: 1.0
// ---------------------------------------------------------------------------
module relu_drain_ctrl
   import relu_drain_ctrl_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int COUNT  = 4,
   parameter int ADDR_W = 8,
   parameter int ROWS_W = 8,
   parameter int NEG_W  = 16
) (
   input  wire logic        clk,
   input  wire logic        rst,
   relu_drain_ctrl_if.slave bus
);

   localparam int C_CNT_W = $clog2(COUNT + 1);

   drain_state_t             r_state;
   logic                     r_apply;
   logic [ROWS_W-1:0]        r_num_rows;
   logic [ADDR_W-1:0]        r_base;
   logic [ROWS_W-1:0]        r_row_idx;
   logic                     r_busy;
   logic                     r_done;
   logic                     r_out_valid;
   logic [ADDR_W-1:0]        r_out_addr;
   logic [COUNT*WIDTH-1:0]   r_out_data;
   logic [NEG_W-1:0]         r_neg;

   logic                     w_in_ready;
   logic                     w_in_hs;
   logic                     w_out_hs;
   logic                     w_ov_next;
   logic [ROWS_W-1:0]        w_idx_next;
   logic [ADDR_W-1:0]        w_addr;
   logic [COUNT*WIDTH-1:0]   w_relu_data;
   logic [C_CNT_W-1:0]       w_row_neg;
   logic [NEG_W:0]           w_neg_sum;
   logic [NEG_W-1:0]         w_neg_next;

   relu_layer #(
      .WIDTH (WIDTH),
      .COUNT (COUNT)
   ) u_relu (
      .i_apply (r_apply),
      .i_data  (bus.in_data),
      .o_data  (w_relu_data)
   );

   // The output register frees up in the same cycle it drains, so a held-high
   // out_ready lets a new row in every cycle.
   assign w_in_ready = (r_state == ST_DRAIN) && (r_row_idx < r_num_rows)
                       && (!r_out_valid || bus.out_ready);
   assign w_in_hs    = bus.in_valid && w_in_ready;
   assign w_out_hs   = r_out_valid && bus.out_ready;
   assign w_ov_next  = w_in_hs || (r_out_valid && !w_out_hs);
   assign w_idx_next = r_row_idx + ROWS_W'(w_in_hs);
   assign w_addr     = r_base + ADDR_W'(r_row_idx);

   always_comb begin
      w_row_neg = '0;
      for (int i = 0; i < COUNT; i++) begin
         w_row_neg = w_row_neg + C_CNT_W'(bus.in_data[sign_bit(i, WIDTH)]);
      end
   end

   assign w_neg_sum  = {1'b0, r_neg} + (NEG_W+1)'(w_row_neg);
   assign w_neg_next = w_neg_sum[NEG_W] ? '1 : w_neg_sum[NEG_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_apply     <= 1'b0;
         r_num_rows  <= '0;
         r_base      <= '0;
         r_row_idx   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_addr  <= '0;
         r_out_data  <= '0;
         r_neg       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_apply    <= bus.cfg_apply_relu;
                  r_num_rows <= bus.cfg_num_rows;
                  r_base     <= bus.cfg_base_addr;
                  r_row_idx  <= '0;
                  r_neg      <= '0;
                  if (bus.cfg_num_rows == '0) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= ST_DRAIN;
                     r_busy  <= 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_in_hs) begin
                  r_out_data <= w_relu_data;
                  r_out_addr <= w_addr;
                  r_row_idx  <= w_idx_next;
                  if (r_apply) begin
                     r_neg <= w_neg_next;
                  end
               end
               r_out_valid <= w_ov_next;
               if ((w_idx_next == r_num_rows) && !w_ov_next) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_addr  = r_out_addr;
   assign bus.out_data  = r_out_data;
   assign bus.neg_count = r_neg;

endmodule
`default_nettype wire
